uart_tx_cfg: RTL

//  Parametrised UART serialiser; successor to the fixed 8N1 transmitter. Configurable data width,

---
 rtl/uart_tx_cfg_pkg.sv | 22 ++
 rtl/uart_tx_cfg_if.sv | 31 +++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx_cfg.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uart_tx_cfg_pkg.sv
// rtl/uart_tx_cfg_pkg.sv - shared UART TX state encoding, defaults and parity helper
package uart_tx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [12:0] BAUD_CNT_DEFAULT = 13'd5207;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    // Payload is zero-extended to 9 bits, so narrower widths give the same result.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - producer-facing handshake and serial-side status bundle
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter, ticks on its last count, held at zero while disabled
module uart_baud_gen #(
    parameter logic [12:0] BAUD_CNT_MAX = 13'd5207
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_bit_tick
);

    localparam int CW = (BAUD_CNT_MAX == 13'd0) ? 1 : $clog2(int'(BAUD_CNT_MAX) + 1);
    localparam logic [CW-1:0] CNT_LAST = BAUD_CNT_MAX[CW-1:0];

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last  = (r_cnt == CNT_LAST);
    assign o_bit_tick = i_en & w_at_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_en || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART serialiser with one-entry holding register
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter logic [12:0] BAUD_CNT_MAX = BAUD_CNT_DEFAULT,
    parameter int          DATA_BITS    = 8,
    parameter int          PARITY_EN    = 0,
    parameter logic        PARITY_ODD   = PARITY_MODE_EVEN,
    parameter int          STOP_BITS    = 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    uart_tx_cfg_if.slave  bus
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_cnt;
    logic                 r_parity;
    logic                 r_tx_done;

    logic                 w_bit_tick;
    logic                 w_baud_en;
    logic                 w_accept;
    logic                 w_frame_end;
    logic                 w_load;
    logic                 w_tx;

    assign w_baud_en   = (r_state != ST_IDLE);
    assign w_accept    = bus.tx_valid & ~r_hold_full;
    assign w_frame_end = (r_state == ST_STOP) && w_bit_tick && (r_bit_cnt == STOP_LAST);
    // A pending word starts either from idle or straight off the last stop bit.
    assign w_load      = r_hold_full && ((r_state == ST_IDLE) || w_frame_end);

    uart_baud_gen #(
        .BAUD_CNT_MAX (BAUD_CNT_MAX)
    ) u_baud_gen (
        .i_clk      (sys_clk),
        .i_rst      (sys_rst),
        .i_en       (w_baud_en),
        .o_bit_tick (w_bit_tick)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (r_hold_full) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_bit_tick) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_tick && (r_bit_cnt == DATA_LAST))
                    w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_bit_tick) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_frame_end) w_state_nxt = r_hold_full ? ST_START : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx = 1'b1;
        unique case (r_state)
            ST_START:  w_tx = 1'b0;
            ST_DATA:   w_tx = r_shift[0];
            ST_PARITY: w_tx = r_parity;
            default:   w_tx = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= 4'd0;
            r_parity    <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_done <= w_frame_end;

            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end

            if (w_load) begin
                r_shift  <= r_hold;
                r_parity <= calc_parity(9'(r_hold), PARITY_ODD);
            end else if ((r_state == ST_DATA) && w_bit_tick) begin
                r_shift <= r_shift >> 1;
            end

            // Bit counter restarts on every state change, so it indexes data and stop bits alike.
            if (w_bit_tick) begin
                if (w_state_nxt != r_state || w_load) begin
                    r_bit_cnt <= 4'd0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

    assign bus.tx       = w_tx;
    assign bus.tx_busy  = (r_state != ST_IDLE);
    assign bus.tx_done  = r_tx_done;
    assign bus.tx_ready = ~r_hold_full;

endmodule
